// File: rtl/gradmm_node_array_tdp_ram.sv
`default_nettype none
// ============================================================================
// Module   : gradmm_node_array_tdp_ram
// Brief    : True-dual-port byte-enable node-array RAM with post-reset clear sweep
// Revision : 1.0 - initial release
// ============================================================================
module gradmm_node_array_tdp_ram #(
  parameter int                   DataWidth    = 32,
  parameter int                   AddressRange = 32,
  parameter int                   AddressWidth = 5,
  parameter int                   READ_LATENCY = 1,
  parameter int                   RDW_MODE     = 0,
  parameter int                   CLR_ON_RESET = 1,
  parameter logic [DataWidth-1:0] INIT_VALUE   = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [AddressWidth-1:0] address0,
  input  logic                    ce0,
  input  logic                    we0,
  input  logic [DataWidth/8-1:0]  be0,
  input  logic [DataWidth-1:0]    d0,
  output logic [DataWidth-1:0]    q0,
  input  logic [AddressWidth-1:0] address1,
  input  logic                    ce1,
  input  logic                    we1,
  input  logic [DataWidth/8-1:0]  be1,
  input  logic [DataWidth-1:0]    d1,
  output logic [DataWidth-1:0]    q1,
  output logic                    init_busy
);

  localparam int                    c_BYTES = DataWidth / 8;
  localparam logic [AddressWidth:0]   c_RANGE = (AddressWidth + 1)'(AddressRange);
  localparam logic [AddressWidth-1:0] c_LAST  = AddressWidth'(AddressRange - 1);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [AddressWidth-1:0] r_ptr;
  logic [DataWidth-1:0]    r_mem [0:AddressRange-1];
  logic                    w_ready;
  logic                    w_wr0;
  logic                    w_wr1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= (CLR_ON_RESET != 0) ? S_CLEAR : S_READY;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_CLEAR) r_ptr <= r_ptr + AddressWidth'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (r_state == S_CLEAR && r_ptr == c_LAST) w_state_next = S_READY;
  end

  assign init_busy = (r_state == S_CLEAR);
  assign w_ready   = (r_state == S_READY) && !reset;
  assign w_wr0     = ce0 && we0 && w_ready && ({1'b0, address0} < c_RANGE);
  assign w_wr1     = ce1 && we1 && w_ready && ({1'b0, address1} < c_RANGE);

  // Port 0 assignments come last so its enabled bytes win a same-address collision.
  always_ff @(posedge clk) begin
    if (!reset && r_state == S_CLEAR) r_mem[r_ptr] <= INIT_VALUE;
    for (int b = 0; b < c_BYTES; b++) begin
      if (w_wr1 && be1[b]) r_mem[address1][8*b +: 8] <= d1[8*b +: 8];
      if (w_wr0 && be0[b]) r_mem[address0][8*b +: 8] <= d0[8*b +: 8];
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [AddressWidth-1:0] w_a;
    logic                    w_ce;
    logic                    w_we;
    logic                    w_rng;
    logic                    w_acc;
    logic [c_BYTES-1:0]      w_be;
    logic [DataWidth-1:0]    w_d;
    logic [DataWidth-1:0]    w_old;
    logic [DataWidth-1:0]    w_rd;
    logic [DataWidth-1:0]    r_s;
    logic [DataWidth-1:0]    r_q;
    logic                    r_v;

    assign w_a   = (p == 0) ? address0 : address1;
    assign w_ce  = (p == 0) ? ce0 : ce1;
    assign w_we  = (p == 0) ? we0 : we1;
    assign w_be  = (p == 0) ? be0 : be1;
    assign w_d   = (p == 0) ? d0 : d1;
    assign w_rng = ({1'b0, w_a} < c_RANGE);
    assign w_acc = w_ce && (r_state == S_READY);

    // Reads see the pre-edge array, so a cross-port write to the same word is never visible.
    always_comb begin
      w_old = w_rng ? r_mem[w_a] : '0;
      w_rd  = w_old;
      if (RDW_MODE == 1 && w_we && w_rng) begin
        for (int b = 0; b < c_BYTES; b++) begin
          if (w_be[b]) w_rd[8*b +: 8] = w_d[8*b +: 8];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_q <= '0;
        r_v <= 1'b0;
      end else begin
        r_v <= w_acc;
        if (w_acc) r_s <= w_rd;
        if (READ_LATENCY == 1) begin
          if (w_acc) r_q <= w_rd;
        end else if (r_v) begin
          r_q <= r_s;
        end
      end
    end
  end

  assign q0 = g_port[0].r_q;
  assign q1 = g_port[1].r_q;

endmodule
`default_nettype wire

// File: tb/tb_gradmm_node_array_tdp_ram.sv
`default_nettype none
// Scoreboard bench: four RAM configurations share clock and reset; each access pushes
// its expected read data, and a negedge monitor compares when the latency expires.
module tb_gradmm_node_array_tdp_ram;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [4:0]  a0 [4];
  logic [4:0]  a1 [4];
  logic        ce0 [4];
  logic        we0 [4];
  logic        ce1 [4];
  logic        we1 [4];
  logic [3:0]  be0 [4];
  logic [3:0]  be1 [4];
  logic [31:0] d0 [4];
  logic [31:0] d1 [4];
  logic [31:0] q0 [4];
  logic [31:0] q1 [4];
  logic        busy [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    gradmm_node_array_tdp_ram #(
      .DataWidth   (32),
      .AddressRange(g == 2 ? 20 : 32),
      .AddressWidth(5),
      .READ_LATENCY((g == 1 || g == 2) ? 2 : 1),
      .RDW_MODE    ((g == 1 || g == 3) ? 1 : 0),
      .CLR_ON_RESET(1),
      .INIT_VALUE  (g == 0 ? 32'hA5A5A5A5 : 32'h0)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .address0 (a0[g]),
      .ce0      (ce0[g]),
      .we0      (we0[g]),
      .be0      (be0[g]),
      .d0       (d0[g]),
      .q0       (q0[g]),
      .address1 (a1[g]),
      .ce1      (ce1[g]),
      .we1      (we1[g]),
      .be1      (be1[g]),
      .d1       (d1[g]),
      .q1       (q1[g]),
      .init_busy(busy[g])
    );
  end

  function automatic int f_ar(int k);
    return (k == 2) ? 20 : 32;
  endfunction
  function automatic int f_lat(int k);
    return (k == 1 || k == 2) ? 2 : 1;
  endfunction
  function automatic int f_rdw(int k);
    return (k == 1 || k == 3) ? 1 : 0;
  endfunction
  function automatic logic [31:0] f_init(int k);
    return (k == 0) ? 32'hA5A5A5A5 : 32'h0;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d, logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) o[8*b +: 8] = d[8*b +: 8];
    return o;
  endfunction

  int vectors = 0;
  int miscompares = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          k;
    int          p;
    logic [31:0] exp;
    int          due;
  } sb_t;

  sb_t         sbq [$];
  logic [31:0] mm [4][32];

  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].due == cyc) begin
        check($sformatf("rd k%0d p%0d", sbq[i].k, sbq[i].p),
              (sbq[i].p == 0) ? q0[sbq[i].k] : q1[sbq[i].k], sbq[i].exp);
        sbq.delete(i);
      end
    end
  end

  // One cycle on instance k: both ports driven, expectations from the shadow array.
  task automatic access(int k,
                        bit c0, bit w0, int ad0, logic [3:0] b0, logic [31:0] x0,
                        bit c1, bit w1, int ad1, logic [3:0] b1, logic [31:0] x1);
    logic [31:0] o0, o1;
    bit          in0, in1;
    ce0[k] = c0; we0[k] = w0; a0[k] = ad0[4:0]; be0[k] = b0; d0[k] = x0;
    ce1[k] = c1; we1[k] = w1; a1[k] = ad1[4:0]; be1[k] = b1; d1[k] = x1;
    in0 = ad0 < f_ar(k);
    in1 = ad1 < f_ar(k);
    o0 = in0 ? mm[k][ad0] : 32'h0;
    o1 = in1 ? mm[k][ad1] : 32'h0;
    if (c0) sbq.push_back('{k, 0, (f_rdw(k) == 1 && w0 && in0) ? merge(o0, x0, b0) : o0,
                            cyc + f_lat(k)});
    if (c1) sbq.push_back('{k, 1, (f_rdw(k) == 1 && w1 && in1) ? merge(o1, x1, b1) : o1,
                            cyc + f_lat(k)});
    if (c1 && w1 && in1) mm[k][ad1] = merge(mm[k][ad1], x1, b1);
    if (c0 && w0 && in0) mm[k][ad0] = merge(mm[k][ad0], x0, b0);
    @(negedge clk);
    ce0[k] = 1'b0; we0[k] = 1'b0; ce1[k] = 1'b0; we1[k] = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(negedge clk);
    if (sbq.size() != 0) begin
      check("sb_drain", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  // Reset pulse, optional re-reset at sample restart_at, then busy-length measurement.
  task automatic reset_seq(int restart_at);
    int cnt [4];
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cnt[k] = 0;
      check($sformatf("rst q0 k%0d", k), q0[k], 32'h0);
      check($sformatf("rst q1 k%0d", k), q1[k], 32'h0);
    end
    for (int n = 0; n < 45; n++) begin
      if (n == restart_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) cnt[k] = 0;
      end
      for (int k = 0; k < 4; k++) if (busy[k]) cnt[k]++;
      if (n == 20) begin
        ce0[0] = 1'b1; we0[0] = 1'b1; a0[0] = 5'd0; be0[0] = 4'hF; d0[0] = 32'h0;
      end else begin
        ce0[0] = 1'b0; we0[0] = 1'b0;
      end
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("busy_cycles k%0d", k), cnt[k], f_ar(k));
      check($sformatf("busy_end k%0d", k), {31'b0, busy[k]}, 32'h0);
      for (int a = 0; a < 32; a++) mm[k][a] = f_init(k);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      a0[k] = '0; a1[k] = '0; ce0[k] = 1'b0; we0[k] = 1'b0; ce1[k] = 1'b0; we1[k] = 1'b0;
      be0[k] = '0; be1[k] = '0; d0[k] = '0; d1[k] = '0;
    end
    repeat (2) @(negedge clk);
    reset_seq(-1);

    // Full readback of the swept array, both ports
    for (int a = 0; a < 32; a++) access(0, 1, 0, a, 4'h0, 32'h0, 1, 0, 31 - a, 4'h0, 32'h0);
    drain();

    // Byte-enable merge across ports on successive cycles
    access(0, 1, 1, 5, 4'hF, 32'h11223344, 0, 0, 0, 4'h0, 32'h0);
    access(0, 0, 0, 0, 4'h0, 32'h0, 1, 1, 5, 4'b0101, 32'hAABBCCDD);
    access(0, 1, 0, 5, 4'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0);
    drain();

    // Read-during-write modes and latencies, cross-port read of the written word
    for (int k = 0; k < 4; k++) begin
      access(k, 1, 1, 9, 4'hF, 32'h0, 0, 0, 0, 4'h0, 32'h0);
      access(k, 1, 1, 9, 4'hF, 32'hDEAD0001, 1, 0, 9, 4'h0, 32'h0);
      access(k, 1, 0, 9, 4'h0, 32'h0, 1, 0, 9, 4'h0, 32'h0);
    end
    drain();

    // Same-address, same-cycle dual write priority
    access(0, 1, 1, 7, 4'b1100, 32'hFFFF0000, 1, 1, 7, 4'hF, 32'h0000BEEF);
    access(0, 1, 0, 7, 4'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0);
    access(0, 1, 1, 7, 4'hF, 32'hFFFF0000, 1, 1, 7, 4'hF, 32'h0000BEEF);
    access(0, 1, 0, 7, 4'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0);
    drain();

    // Out-of-range access on the 20-word instance
    access(2, 1, 1, 25, 4'hF, 32'h12345678, 0, 0, 0, 4'h0, 32'h0);
    access(2, 1, 0, 25, 4'h0, 32'h0, 1, 0, 25, 4'h0, 32'h0);
    for (int a = 0; a < 20; a++) access(2, 1, 0, a, 4'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0);
    drain();

    // Reset mid-sweep restarts the clear
    reset_seq(10);
    access(2, 1, 0, 19, 4'h0, 32'h0, 1, 0, 0, 4'h0, 32'h0);
    access(0, 1, 0, 0, 4'h0, 32'h0, 1, 0, 31, 4'h0, 32'h0);
    drain();

    // Back-to-back random traffic on the two-cycle-latency instances
    foreach (mm[k]) begin
      if (k == 1 || k == 2) begin
        for (int n = 0; n < 64; n++) begin
          access(k, 1, ($urandom_range(3) == 0), int'($urandom_range(31)), 4'($urandom), $urandom,
                 1, ($urandom_range(3) == 0), int'($urandom_range(31)), 4'($urandom), $urandom);
        end
        drain();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
